// File: rtl/counter_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : counter_rr_sched
//  Purpose  : Round-robin scheduler for one shared event counter. Up to four
//             requesters compete for a counting window. The winner's target
//             is latched at grant. Events are counted until the target is
//             reached, and the winner then gets a one-cycle done pulse.
//
//  Ports    : clk       - rising-edge clock
//             resetn    - asynchronous active-low reset
//             req[3:0]  - level request per requester, held until done/abandon
//             tgt       - packed targets, requester i at [i*WIDTH +: WIDTH]
//             event_in  - one count per high cycle while a window is open
//             gnt[3:0]  - one-hot grant, zero when idle
//             busy      - high while any grant is held
//             done[3:0] - one-cycle completion pulse to the granted requester
//             count     - current value of the shared counter
//
//  Revision : 1.0  initial release
// ============================================================================
module counter_rr_sched #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] tgt,
    input  logic               event_in,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic [3:0]         done,
    output logic [WIDTH-1:0]   count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_COUNT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_gnt;
    logic             r_busy;
    logic [3:0]       r_done;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_tgt_q;
    logic [1:0]       r_ptr;
    logic [1:0]       r_winner;

    logic             w_found;
    logic [1:0]       w_win_idx;
    logic [1:0]       w_idx;

    // Search the request vector starting at the round-robin pointer. The
    // two-bit index wraps naturally, which gives the modulo-4 rotation.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = 2'd0;
        w_idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= c_IDLE;
            r_gnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 4'd0;
            r_count  <= '0;
            r_tgt_q  <= '0;
            r_ptr    <= 2'd0;
            r_winner <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 4'd0;
                    if (w_found) begin
                        r_state  <= c_COUNT;
                        r_gnt    <= 4'b0001 << w_win_idx;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                        r_tgt_q  <= tgt[w_win_idx*WIDTH +: WIDTH];
                        r_winner <= w_win_idx;
                    end
                end
                c_COUNT: begin
                    // An abandoned window takes precedence over completion:
                    // a requester that has gone away is never sent done.
                    if (!req[r_winner]) begin
                        r_state <= c_IDLE;
                        r_gnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_winner + 2'd1;
                    end else if (r_count == r_tgt_q) begin
                        // Reaching the target stops counting, so the counter
                        // can never pass tgt_q and therefore never wraps.
                        r_state <= c_DONE;
                        r_done  <= r_gnt;
                    end else if (event_in) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done  <= 4'd0;
                    r_gnt   <= 4'd0;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_winner + 2'd1;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_done  <= 4'd0;
                    r_gnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign busy  = r_busy;
    assign done  = r_done;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_rr_sched
//  Purpose  : Self-checking bench for counter_rr_sched. Directed scenarios
//             followed by a randomized run against a behavioural model that
//             tracks owner / count / target / pointer directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_rr_sched;

    localparam int W = 8;

    logic           clk;
    logic           resetn;
    logic [3:0]     req;
    logic [4*W-1:0] tgt;
    logic           event_in;
    logic [3:0]     gnt;
    logic           busy;
    logic [3:0]     done;
    logic [W-1:0]   count;

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the counter (-1 none), its count and
    // target, the rotation pointer, and whether this is the done cycle.
    int m_owner;
    int m_cnt;
    int m_tgt;
    int m_ptr;
    bit m_dphase;

    counter_rr_sched #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .tgt      (tgt),
        .event_in (event_in),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_tgt = 0; m_ptr = 0; m_dphase = 0;
    endtask

    task automatic model_edge();
        if (m_dphase) begin
            m_dphase = 0;
            m_ptr    = (m_owner + 1) % 4;
            m_owner  = -1;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else if (m_cnt == m_tgt) begin
                m_dphase = 1;
            end else if (event_in) begin
                m_cnt++;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (m_owner < 0 && req[i]) begin
                    m_owner = i;
                    m_cnt   = 0;
                    m_tgt   = int'((tgt >> (i * W)) & 32'hFF);
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        chk("gnt",   32'(gnt),   32'(eg));
        chk("busy",  32'(busy),  32'(eg != 4'd0));
        chk("done",  32'(done),  m_dphase ? 32'(eg) : 32'd0);
        chk("count", 32'(count), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),   32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    task automatic do_reset();
        req = 4'd0; event_in = 1'b0; tgt = '0;
        resetn = 1'b0;
        #1;
        check_zero("reset");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    logic [3:0] grants[$];
    int         gstep[$];
    logic [3:0] prev_g;
    logic [3:0] fair_exp [5];
    logic [3:0] nreq;

    initial begin
        resetn = 1'b0; req = 4'd0; tgt = '0; event_in = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Single window: target 3, continuous events.
        req = 4'b0001; tgt[0*W +: W] = 8'd3; event_in = 1'b1;
        step(); chk("single_gnt1", 32'(gnt), 32'h1); chk("single_cnt1", 32'(count), 32'd0);
        step(); step(); step();
        chk("single_cnt4", 32'(count), 32'd3);
        step(); chk("single_done5", 32'(done), 32'h1); chk("single_gnt5", 32'(gnt), 32'h1);
        req = 4'b0000;
        step(); chk("single_gnt6", 32'(gnt), 32'h0);

        // Fairness: all requesting with target 1.
        do_reset();
        req = 4'b1111; tgt = {8'd1, 8'd1, 8'd1, 8'd1}; event_in = 1'b1;
        prev_g = 4'd0;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (prev_g == 4'd0 && gnt != 4'd0) begin
                grants.push_back(gnt);
                gstep.push_back(s);
            end
            prev_g = gnt;
        end
        fair_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair_gnt%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'hDEAD, 32'(fair_exp[i]));
            chk($sformatf("fair_step%0d", i), (i < gstep.size()) ? 32'(gstep[i]) : 32'hDEAD, 32'(1 + 4 * i));
        end
        req = 4'b0000;
        step();

        // Sparse events: target 2, event every third cycle.
        do_reset();
        req = 4'b0001; tgt[0*W +: W] = 8'd2;
        for (int s = 0; s < 12; s++) begin
            event_in = (s % 3 == 2);
            step();
            if (done != 4'd0) req = 4'b0000;
        end

        // Zero target.
        do_reset();
        req = 4'b0100; tgt[2*W +: W] = 8'd0; event_in = 1'b0;
        step(); chk("zero_gnt1", 32'(gnt), 32'h4); chk("zero_done1", 32'(done), 32'h0);
        step(); chk("zero_done2", 32'(done), 32'h4); chk("zero_gnt2", 32'(gnt), 32'h4);
        chk("zero_cnt2", 32'(count), 32'd0);
        req = 4'b0000;
        step(); chk("zero_gnt3", 32'(gnt), 32'h0);

        // Abort: requester 1 drops at count 1, requester 2 pending.
        do_reset();
        req = 4'b0110; tgt[1*W +: W] = 8'd5; tgt[2*W +: W] = 8'd1; event_in = 1'b1;
        step(); chk("abort_gnt1", 32'(gnt), 32'h2);
        step(); chk("abort_cnt2", 32'(count), 32'd1);
        req = 4'b0100;
        step(); chk("abort_gnt3", 32'(gnt), 32'h0); chk("abort_cnt3", 32'(count), 32'd1);
        chk("abort_done3", 32'(done), 32'h0);
        step(); chk("abort_gnt4", 32'(gnt), 32'h4);
        step(); step(); step();
        req = 4'b0000;
        step();

        // Reset in the middle of a window.
        do_reset();
        req = 4'b0001; tgt[0*W +: W] = 8'd9; event_in = 1'b1;
        for (int s = 0; s < 5; s++) step();
        chk("rstmid_cnt", 32'(count), 32'd4);
        #1 resetn = 1'b0;
        #1 check_zero("rstmid");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        req = 4'b1010;
        step(); chk("rstmid_gnt", 32'(gnt), 32'h2);

        // Randomized traffic against the model.
        for (int s = 0; s < 600; s++) begin
            event_in = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) tgt[i*W +: W] = 8'($urandom_range(0, 5));
            for (int i = 0; i < 4; i++) begin
                if (i == m_owner && !m_dphase)
                    nreq[i] = ($urandom_range(0, 19) != 0);
                else
                    nreq[i] = 1'($urandom_range(0, 1));
            end
            req = nreq;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_rr_sched.md
COUNTER_RR_SCHED -- requirements
Module: counter_rr_sched

Interface
REQ-001 Parameter: WIDTH, default 8, width of count and of each target field.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester request for a counting window; level, held until done or abandoned.
REQ-005 Port: tgt  input  4*WIDTH  packed targets; requester i uses bits [i*WIDTH +: WIDTH].
REQ-006 Port: event_in  input  1  event to be counted; one count per high cycle.
REQ-007 Port: gnt  output  4  one-hot grant to the requester owning the counter; all-zero when none.
REQ-008 Port: busy  output  1  high while any grant is held.
REQ-009 Port: done  output  4  one-cycle pulse to the granted requester on window completion.
REQ-010 Port: count  output  WIDTH  current value of the shared counter.

Function
REQ-011 The block SHALL implement FSM states IDLE, COUNT, DONE with registered outputs.
REQ-012 In IDLE, with req nonzero, the block SHALL pick the first set req bit at or after rr_ptr (modulo 4), cyclically.
REQ-013 On that pick the block SHALL, at the next edge, enter COUNT, set gnt one-hot for the winner, clear count to 0, and latch the winner's tgt field as tgt_q.
REQ-014 Grant latency SHALL be one cycle: req sampled high in cycle N gives gnt high in cycle N+1.
REQ-015 tgt SHALL be sampled only at grant; later tgt changes SHALL NOT affect the active window.
REQ-016 In COUNT, each cycle event_in=1 SHALL increment count by 1; event_in=0 SHALL hold count.
REQ-017 When count==tgt_q in COUNT, the block SHALL enter DONE at the next edge; event_in that cycle SHALL NOT increment.
REQ-018 tgt_q=0 SHALL give COUNT for exactly one cycle then DONE, independent of event_in.
REQ-019 count SHALL never wrap: it stops at tgt_q (<= 2^WIDTH-1) before any overflow.
REQ-020 In DONE (one cycle), done[winner] SHALL be 1, gnt SHALL stay asserted, count SHALL hold; next state is IDLE.
REQ-021 On leaving DONE, rr_ptr SHALL become (winner+1) mod 4 and gnt SHALL go to 0.
REQ-022 If the granted requester drops req during COUNT, the block SHALL enter IDLE at the next edge without a done pulse; gnt drops, count holds, rr_ptr becomes (winner+1) mod 4.
REQ-023 req from non-granted requesters SHALL be ignored during COUNT and DONE.
REQ-024 IDLE SHALL last at least one cycle between windows; back-to-back grants are DONE->IDLE->COUNT.
REQ-025 count SHALL hold its last value in IDLE until the next grant clears it.
REQ-026 busy SHALL equal (gnt != 0).
REQ-027 done SHALL be zero in every cycle outside DONE and at most one bit SHALL be set.

Reset
REQ-028 resetn low SHALL asynchronously force state IDLE, gnt=0, done=0, busy=0, count=0, rr_ptr=0, tgt_q=0.
REQ-029 Reset mid-window SHALL abandon it with no done pulse; after release the first grant SHALL follow REQ-012 with rr_ptr=0.
REQ-030 Outputs SHALL be stable and valid from the first clk edge after resetn deasserts.

Verification
REQ-031 Single: req=0001, tgt0=3, event_in high continuously -> gnt=0001 in cycle 1, count 0,1,2,3, done=0001 in cycle 5, gnt=0 in cycle 6.
REQ-032 Fairness: req=1111 held, all targets 1, event_in=1 -> grants in order 0001,0010,0100,1000,0001, each window 3 cycles plus 1 IDLE.
REQ-033 Sparse events: tgt=2, event_in pulsed every 3rd cycle -> count steps only on pulses; done one cycle after count reaches 2.
REQ-034 Zero target: req=0100, tgt2=0, event_in=0 -> gnt=0100 for 2 cycles (COUNT, DONE), done=0100 in the second, count=0.
REQ-035 Abort: req1 drops while count=1 of tgt 5 -> no done, gnt=0 next cycle, count holds 1, next grant to requester 2 if pending.
REQ-036 Reset mid-window: resetn low at count=4 -> all outputs 0 immediately; after release req=1010 grants requester 1 first.
